// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage, the ID-stage controller and the
// synchronous instruction memory.
interface fetch_if #(parameter int PC_WIDTH = 16);
  logic                en_pc;
  logic                en_ifid;
  logic                flush_ifid;
  logic                jump;
  logic [PC_WIDTH-1:0] jump_target;
  logic                is_halt;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [15:0]         imem_rdata;
  logic [15:0]         inst_id;
  logic [PC_WIDTH-1:0] pc_id;
  logic [PC_WIDTH-1:0] pc_plus1_id;
  logic                flushed;
  logic                halted;

  modport master (
    input  en_pc, en_ifid, flush_ifid, jump, jump_target, is_halt, imem_rdata,
    output imem_addr, inst_id, pc_id, pc_plus1_id, flushed, halted
  );

  modport slave (
    output en_pc, en_ifid, flush_ifid, jump, jump_target, is_halt, imem_rdata,
    input  imem_addr, inst_id, pc_id, pc_plus1_id, flushed, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register. The memory read-data port acts as the
// IF/ID instruction register; hold_reg preserves it across stalls.
module fetch_stage #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master fif
);

  // state | meaning
  // FILL  | first cycle after reset, pipeline empty, ID shows a bubble
  // RUN   | normal fetch; jump > flush > halt > stall > advance
  // HALT  | stopped by HLT, absorbing until reset
  typedef enum logic [1:0] {FILL, RUN, HALT} state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state;
  logic [PC_WIDTH-1:0] pc_f;
  logic [PC_WIDTH-1:0] pc_id_r;
  logic [15:0]         hold_reg;
  logic                hold_v;
  logic                flushed_r;
  logic                halted_r;
  logic                stall;
  logic [15:0]         inst_cur;

  assign stall    = !fif.en_pc || !fif.en_ifid;
  assign inst_cur = hold_v ? hold_reg : fif.imem_rdata;

  assign fif.imem_addr   = pc_f;
  assign fif.inst_id     = flushed_r ? 16'h0000 : inst_cur;
  assign fif.pc_id       = pc_id_r;
  assign fif.pc_plus1_id = pc_id_r + PC_ONE;
  assign fif.flushed     = flushed_r;
  assign fif.halted      = halted_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      pc_f      <= RESET_PC;
      pc_id_r   <= RESET_PC;
      hold_reg  <= 16'h0000;
      hold_v    <= 1'b0;
      flushed_r <= 1'b1;
      halted_r  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          pc_f      <= RESET_PC + PC_ONE;
          pc_id_r   <= RESET_PC;
          hold_v    <= 1'b0;
          flushed_r <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          if (fif.jump) begin
            pc_f      <= fif.jump_target;
            hold_v    <= 1'b0;
            flushed_r <= 1'b1;
          end else if (fif.flush_ifid) begin
            hold_v    <= 1'b0;
            flushed_r <= 1'b1;
            if (fif.en_pc) begin
              pc_f    <= pc_f + PC_ONE;
              pc_id_r <= pc_f;
            end
          end else if (fif.is_halt && !stall) begin
            state     <= HALT;
            flushed_r <= 1'b1;
            halted_r  <= 1'b1;
          end else if (stall) begin
            // A bubble is never captured; the flushed flag simply persists.
            if (!hold_v && !flushed_r) begin
              hold_reg <= inst_cur;
              hold_v   <= 1'b1;
            end
          end else begin
            pc_f      <= pc_f + PC_ONE;
            pc_id_r   <= pc_f;
            hold_v    <= 1'b0;
            flushed_r <= 1'b0;
          end
        end
        HALT: begin
          flushed_r <= 1'b1;
          halted_r  <= 1'b1;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
